// File: rtl/dm_trace_prefetch_issuer.sv
// dm_trace_prefetch_issuer
// Consumes trace entries and, for loads/stores that sit inside a lookahead
// window ahead of the core, issues line-fill requests to a direct-mapped cache.
// A per-line tracker (occupied / processing / tag) suppresses duplicate fills.
// Only one request is ever in flight.
// Optional build macro: KUUGA_ISSUER_STATS_EN enables the hit/miss/stale
// counters; without it the counter outputs are tied to zero.
module dm_trace_prefetch_issuer #(
  parameter int TRACE_ENTRIES    = 131072,
  parameter int INSTR_DATA_WIDTH = 32,
  parameter int DATA_ADDR_WIDTH  = 32,
  parameter int CACHE_LINES      = 64,
  parameter int LINE_BYTES       = 16,
  parameter int LOOKAHEAD        = 8,
  localparam int TIW = $clog2(TRACE_ENTRIES),
  localparam int IW  = $clog2(CACHE_LINES),
  localparam int OW  = $clog2(LINE_BYTES)
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        trace_valid_i,
  output logic                        trace_ready_o,
  input  logic [INSTR_DATA_WIDTH-1:0] trace_instr_i,
  input  logic [DATA_ADDR_WIDTH-1:0]  trace_mem_addr_i,
  input  logic [TIW-1:0]              trace_index_i,
  input  logic [TIW-1:0]              cpu_trace_index_i,
  input  logic                        flush_i,
  output logic                        req_valid_o,
  input  logic                        req_ready_i,
  output logic [DATA_ADDR_WIDTH-1:0]  req_addr_o,
  output logic [TIW-1:0]              req_trace_index_o,
  input  logic                        fill_done_i,
  input  logic [IW-1:0]               fill_line_i,
  output logic [31:0]                 hit_count_o,
  output logic [31:0]                 miss_count_o,
  output logic [31:0]                 stale_count_o
);

  localparam int TAGW = DATA_ADDR_WIDTH - OW;

  localparam logic [2:0] IDLE                = 3'd0;
  localparam logic [2:0] LOOKUP              = 3'd1;
  localparam logic [2:0] MAKE_REQUEST        = 3'd2;
  localparam logic [2:0] WAIT_FOR_PROCESSING = 3'd3;
  localparam logic [2:0] REQUEST_RETIRED     = 3'd4;

  logic [2:0]                 state_q, state_d;
  logic                       readyEn_q;
  logic [IW-1:0]              line_q;
  logic [TAGW-1:0]            tag_q;
  logic [TIW-1:0]             index_q;
  logic [DATA_ADDR_WIDTH-1:0] reqAddr_q;
  logic [TIW-1:0]             reqIndex_q;
  logic [CACHE_LINES-1:0]     occupied_q, occupied_d;
  logic [CACHE_LINES-1:0]     processing_q, processing_d;
  logic [TAGW-1:0]            trkTag_q [CACHE_LINES];

  logic [6:0]      opcode;
  logic            isMemOp;
  logic [TIW-1:0]  distance;
  logic            isStale;
  logic            inWindow;
  logic            outOfWindow;
  logic [IW-1:0]   entryLine;
  logic [TAGW-1:0] entryTag;
  logic            accept;
  logic            acceptMem;
  logic            lookupHit;
  logic            lookupBusy;
  logic            lookupAlloc;
  logic            reqFire;
  logic            fillMatch;
  logic            unusedBits;

  // Decode the offered entry: opcode class, distance ahead of the core and
  // cache placement. Modulo subtraction makes index wrap transparent.
  always_comb begin
    opcode      = trace_instr_i[6:0];
    isMemOp     = (opcode == 7'b0000011) || (opcode == 7'b0100011);
    distance    = trace_index_i - cpu_trace_index_i;
    isStale     = distance[TIW-1];
    inWindow    = !isStale && (distance < TIW'(LOOKAHEAD));
    outOfWindow = isMemOp && !isStale && !inWindow;
    entryLine   = trace_mem_addr_i[OW +: IW];
    entryTag    = trace_mem_addr_i[DATA_ADDR_WIDTH-1:OW];
  end

  // Handshake and tracker lookup qualifiers. Ready is held off for one cycle
  // out of reset so the port reads 0 while reset is applied.
  always_comb begin
    trace_ready_o = readyEn_q && (state_q == IDLE) && !outOfWindow;
    accept        = trace_valid_i && trace_ready_o;
    acceptMem     = accept && isMemOp && !isStale;
    lookupHit     = occupied_q[line_q] && (trkTag_q[line_q] == tag_q);
    lookupBusy    = processing_q[line_q];
    lookupAlloc   = (state_q == LOOKUP) && !lookupHit && !lookupBusy;
    reqFire       = (state_q == MAKE_REQUEST) && req_ready_i;
    fillMatch     = fill_done_i && (fill_line_i == line_q);
    unusedBits    = ^{trace_instr_i[INSTR_DATA_WIDTH-1:7], trace_mem_addr_i[OW-1:0]};
  end

  // Next-state logic for the issue FSM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:                if (acceptMem) state_d = LOOKUP;
      LOOKUP: begin
        if (lookupHit)        state_d = IDLE;
        else if (!lookupBusy) state_d = MAKE_REQUEST;
      end
      MAKE_REQUEST:        if (req_ready_i) state_d = WAIT_FOR_PROCESSING;
      WAIT_FOR_PROCESSING: if (fillMatch) state_d = REQUEST_RETIRED;
      REQUEST_RETIRED:     state_d = IDLE;
      default:             state_d = IDLE;
    endcase
  end

  // State register plus the one-shot ready enable after reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      readyEn_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      readyEn_q <= 1'b1;
    end
  end

  // Latch the accepted memory entry for the lookup and request phases.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      line_q  <= '0;
      tag_q   <= '0;
      index_q <= '0;
    end else if ((state_q == IDLE) && acceptMem) begin
      line_q  <= entryLine;
      tag_q   <= entryTag;
      index_q <= trace_index_i;
    end
  end

  // Request payload is captured once at allocation and held until the next
  // allocation, so it stays stable while the cache back-pressures.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      reqAddr_q  <= '0;
      reqIndex_q <= '0;
    end else if (lookupAlloc) begin
      reqAddr_q  <= {tag_q, {OW{1'b0}}};
      reqIndex_q <= index_q;
    end
  end

  // Tracker flag updates. Retirement is applied after flush so a line that
  // retires in the flush cycle still ends up occupied.
  always_comb begin
    occupied_d   = occupied_q;
    processing_d = processing_q;
    if (flush_i) occupied_d = '0;
    if (lookupAlloc) begin
      occupied_d[line_q]   = 1'b0;
      processing_d[line_q] = 1'b1;
    end
    if (state_q == REQUEST_RETIRED) begin
      occupied_d[line_q]   = 1'b1;
      processing_d[line_q] = 1'b0;
    end
  end

  // Tracker storage: flag vectors and the per-line tag array.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      occupied_q   <= '0;
      processing_q <= '0;
      for (int i = 0; i < CACHE_LINES; i++) trkTag_q[i] <= '0;
    end else begin
      occupied_q   <= occupied_d;
      processing_q <= processing_d;
      if (lookupAlloc) trkTag_q[line_q] <= tag_q;
    end
  end

  assign req_valid_o       = (state_q == MAKE_REQUEST);
  assign req_addr_o        = reqAddr_q;
  assign req_trace_index_o = reqIndex_q;

`ifdef KUUGA_ISSUER_STATS_EN
  logic [31:0] hitCount_q, missCount_q, staleCount_q;
  logic        hitInc, missInc, staleInc;

  assign hitInc   = (state_q == LOOKUP) && lookupHit;
  assign missInc  = reqFire;
  assign staleInc = (state_q == IDLE) && accept && isMemOp && isStale;

  // Saturating event counters.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hitCount_q   <= '0;
      missCount_q  <= '0;
      staleCount_q <= '0;
    end else begin
      if (hitInc && (hitCount_q != 32'hFFFF_FFFF))     hitCount_q   <= hitCount_q + 32'd1;
      if (missInc && (missCount_q != 32'hFFFF_FFFF))   missCount_q  <= missCount_q + 32'd1;
      if (staleInc && (staleCount_q != 32'hFFFF_FFFF)) staleCount_q <= staleCount_q + 32'd1;
    end
  end

  assign hit_count_o   = hitCount_q;
  assign miss_count_o  = missCount_q;
  assign stale_count_o = staleCount_q;
`else
  assign hit_count_o   = 32'd0;
  assign miss_count_o  = 32'd0;
  assign stale_count_o = 32'd0;
`endif

endmodule
